// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM encoding
// and the iteration counter sizing helper.
package divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIN  = ST_FIN
    } state_t;

    // Counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: trial subtract of the
// divisor from the shifted partial remainder, restore on borrow.
module restoring_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r_sh_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_o,
    output logic             q_o
);

    logic [WIDTH:0] diff;
    logic           no_borrow;

    // R' - D as R' + ~{0,D} + 1; carry-out set means R' >= D.
    ripple_carry_adder #(.WIDTH(WIDTH + 1)) u_sub (
        .a_i (r_sh_i),
        .b_i (~{1'b0, d_i}),
        .ci_i(1'b1),
        .s_o (diff),
        .co_o(no_borrow)
    );

    assign q_o = no_borrow;
    assign r_o = no_borrow ? diff : r_sh_i;

endmodule

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder built from full-adder cells,
// shared with the add/sub datapath.
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o
);

    logic [WIDTH:0] c;

    assign c[0] = ci_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign co_o = c[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per
// clock, behind a START/DONE handshake.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_ZERO
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic             dz_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             divz_q;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_d;
    logic             qbit_d;

    assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .r_sh_i(r_sh),
        .d_i   (d_q),
        .r_o   (r_d),
        .q_o   (qbit_d)
    );

    // Control FSM, iteration datapath and registered outputs.
    // BUSY/DONE follow the state one cycle late, so they are
    // never high together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            divz_q  <= 1'b0;
        end else begin
            busy_q <= (state_q == RUN);
            done_q <= (state_q == FIN);
            unique case (state_q)
                RUN: begin
                    r_q   <= r_d;
                    q_q   <= {q_q[WIDTH-2:0], qbit_d};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_q <= FIN;
                end
                FIN: begin
                    quo_q   <= q_q;
                    rem_q   <= r_q[WIDTH-1:0];
                    divz_q  <= dz_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (START && state_q != RUN) begin
                if (state_q == IDLE) divz_q <= 1'b0;
                d_q   <= DIVISOR;
                cnt_q <= CW'(WIDTH);
                if (DIVISOR == '0) begin
                    r_q     <= {1'b0, DIVIDEND};
                    q_q     <= '1;
                    dz_q    <= 1'b1;
                    state_q <= FIN;
                end else begin
                    r_q     <= '0;
                    q_q     <= DIVIDEND;
                    dz_q    <= 1'b0;
                    state_q <= RUN;
                end
            end
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign QUOTIENT  = quo_q;
    assign REMAINDER = rem_q;
    assign DIV_ZERO  = divz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: WIDTH=8 vectors and
// corner sequences, plus exhaustive WIDTH=4 sweep.
module tb_restoring_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       st8, busy8, done8, dz8;
    logic [7:0] a8, b8, q8, r8;
    logic       st4, busy4, done4, dz4;
    logic [3:0] a4, b4, q4, r4;

    restoring_divider #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .START(st8),
        .DIVIDEND(a8), .DIVISOR(b8),
        .BUSY(busy8), .DONE(done8),
        .QUOTIENT(q8), .REMAINDER(r8), .DIV_ZERO(dz8)
    );

    restoring_divider #(.WIDTH(4)) dut4 (
        .CLK(clk), .RST(rst), .START(st4),
        .DIVIDEND(a4), .DIVISOR(b4),
        .BUSY(busy4), .DONE(done4),
        .QUOTIENT(q4), .REMAINDER(r4), .DIV_ZERO(dz4)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[8];

    // Issue one WIDTH=8 op and check BUSY/DONE per cycle.
    task automatic op8(input vec_t v);
        int n;
        n = v.dz ? 1 : 9;
        a8 = v.a; b8 = v.b; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        for (int k = 1; k <= n; k++) begin
            tick();
            chk($sformatf("tim %0d/%0d c%0d", v.a, v.b, k),
                {30'd0, busy8, done8},
                {30'd0, (!v.dz && k <= 8), (k == n)});
        end
        chk($sformatf("res %0d/%0d", v.a, v.b),
            {15'd0, q8, r8, dz8}, {15'd0, v.q, v.r, v.dz});
        tick();
        chk($sformatf("hold %0d/%0d", v.a, v.b),
            {13'd0, busy8, done8, q8, r8, dz8},
            {13'd0, 1'b0, 1'b0, v.q, v.r, v.dz});
    endtask

    initial begin
        int lat, eq, er, edz, elat;
        bit seen;

        vecs[0] = '{a: 100, b: 7,  q: 14,  r: 2,  dz: 0};
        vecs[1] = '{a: 255, b: 1,  q: 255, r: 0,  dz: 0};
        vecs[2] = '{a: 5,   b: 9,  q: 0,   r: 5,  dz: 0};
        vecs[3] = '{a: 0,   b: 3,  q: 0,   r: 0,  dz: 0};
        vecs[4] = '{a: 77,  b: 0,  q: 255, r: 77, dz: 1};
        vecs[5] = '{a: 10,  b: 3,  q: 3,   r: 1,  dz: 0};
        vecs[6] = '{a: 200, b: 13, q: 15,  r: 5,  dz: 0};
        vecs[7] = '{a: 250, b: 16, q: 15,  r: 10, dz: 0};

        rst = 1'b1;
        st8 = 1'b0; a8 = '0; b8 = '0;
        st4 = 1'b0; a4 = '0; b4 = '0;
        tick();
        tick();
        chk("reset8", {13'd0, busy8, done8, q8, r8, dz8}, 32'd0);
        chk("reset4", {21'd0, busy4, done4, q4, r4, dz4}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle8", {13'd0, busy8, done8, q8, r8, dz8}, 32'd0);

        foreach (vecs[i]) op8(vecs[i]);

        // START pulsed mid-run is ignored.
        a8 = 200; b8 = 13; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) begin st8 = 1'b1; a8 = 9; b8 = 2; end
            tick();
            if (k == 4) st8 = 1'b0;
            chk($sformatf("ign c%0d", k), {30'd0, busy8, done8},
                {30'd0, (k <= 8), (k == 9)});
            if (k == 9)
                chk("ign res", {16'd0, q8, r8}, {16'd0, 8'd15, 8'd5});
        end

        // START held high through FIN: back-to-back issue.
        a8 = 100; b8 = 7; st8 = 1'b1;
        tick();
        a8 = 9; b8 = 2;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 9) st8 = 1'b0;
            chk($sformatf("b2b c%0d", k), {30'd0, busy8, done8},
                {30'd0, ((k <= 8) || (k >= 10 && k <= 17)),
                 (k == 9 || k == 18)});
            if (k == 9)
                chk("b2b res1", {16'd0, q8, r8}, {16'd0, 8'd14, 8'd2});
            if (k == 18)
                chk("b2b res2", {16'd0, q8, r8}, {16'd0, 8'd4, 8'd1});
        end
        tick();

        // Asynchronous reset mid-run.
        a8 = 100; b8 = 7; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        rst = 1'b1;
        #1;
        chk("async rst", {13'd0, busy8, done8, q8, r8, dz8}, 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done8 || busy8) seen = 1'b1;
        end
        chk("no done after rst", {31'd0, seen}, 32'd0);
        op8('{a: 50, b: 6, q: 8, r: 2, dz: 0});

        // Exhaustive WIDTH=4 sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 15; er = a; edz = 1; elat = 1;
                end else begin
                    eq = a / b; er = a % b; edz = 0; elat = 5;
                end
                a4 = 4'(a); b4 = 4'(b); st4 = 1'b1;
                tick();
                st4 = 1'b0;
                lat = 0;
                while (!done4 && lat < 10) begin
                    tick();
                    lat++;
                end
                chk($sformatf("w4 %0d/%0d", a, b),
                    {lat[7:0], 11'd0, q4, r4, 3'd0, dz4},
                    {elat[7:0], 11'd0, eq[3:0], er[3:0], 3'd0, edz[0]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
